// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between the control FSM (master) and the
// multicycle shift unit (slave).
interface shift_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, shamt, data_in,
        input  data_out, busy, done
    );

    modport slave (
        input  start, op, shamt, data_in,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multicycle shifter: SLL/SRL/SRA/ROR one bit per clock, with a
// start/busy/done handshake and a result register that holds until the next start.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;
    logic [1:0]       op_q_r;
    logic             busy_r;
    logic             done_r;

    // Single-position shift of the accumulator for the latched operation.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] a,
                                                input logic [1:0]       o);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = {a[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, a[WIDTH-1:1]};
            2'b10:   r = {a[WIDTH-1], a[WIDTH-1:1]};
            2'b11:   r = {a[0], a[WIDTH-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    // Control FSM; busy/done are registered alongside the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {SHW{1'b0}};
            op_q_r  <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        acc_r   <= bus.data_in;
                        cnt_r   <= bus.shamt;
                        op_q_r  <= bus.op;
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                SHIFT: begin
                    // cnt counts remaining positions and stops at zero, so it never wraps.
                    if (cnt_r != {SHW{1'b0}}) begin
                        acc_r  <= shift1(acc_r, op_q_r);
                        cnt_r  <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
                        done_r <= 1'b0;
                    end else begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                    busy_r <= 1'b1;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = acc_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, random
// operations against an arithmetic reference, and handshake/reset corner cases.
module tb_shift_sequencer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    shift_sequencer_if #(.WIDTH(32), .SHW(5)) sif ();

    shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input int n, input logic [31:0] x);
        case (o)
            2'b00:   return x << n;
            2'b01:   return x >> n;
            2'b10:   return $unsigned($signed(x) >>> n);
            default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
        endcase
    endfunction

    task automatic scramble();
        sif.data_in = $urandom;
        sif.op      = 2'($urandom_range(0, 3));
        sif.shamt   = 5'($urandom_range(0, 31));
    endtask

    // Start one operation, wait for done while disturbing the inputs, then check.
    task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] s,
                          input logic [31:0] d, input logic [31:0] exp);
        int  edges;
        int  busy_cycles;
        bit  seen;
        edges = 0; busy_cycles = 0; seen = 1'b0;
        @(negedge clk);
        sif.start = 1'b1; sif.op = o; sif.shamt = s; sif.data_in = d;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        sif.start = 1'b0;
        scramble();
        for (int k = 0; k < 40; k++) begin
            if (sif.busy) busy_cycles++;
            if (sif.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            scramble();
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(edges), 32'(int'(s) + 2));
        check({name, " busy_cycles"}, 32'(busy_cycles), 32'(int'(s) + 2));
        check({name, " data_out"}, sif.data_out, exp);
        @(negedge clk);
        check({name, " done_after"}, 32'(sif.done), 32'd0);
        check({name, " busy_after"}, 32'(sif.busy), 32'd0);
        check({name, " hold"}, sif.data_out, exp);
    endtask

    vec_t vecs[6];

    initial begin
        int          done_cnt;
        logic [1:0]  ro;
        logic [4:0]  rs;
        logic [31:0] rd;

        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        sif.start = 1'b0; sif.op = 2'b00; sif.shamt = 5'd0; sif.data_in = 32'd0;

        vecs[0] = '{op: 2'b00, shamt: 5'd4,  din: 32'h0000_00F1, dout: 32'h0000_0F10};
        vecs[1] = '{op: 2'b10, shamt: 5'd16, din: 32'h8000_1234, dout: 32'hFFFF_8000};
        vecs[2] = '{op: 2'b01, shamt: 5'd16, din: 32'h8000_1234, dout: 32'h0000_8000};
        vecs[3] = '{op: 2'b11, shamt: 5'd8,  din: 32'h1234_5678, dout: 32'h7812_3456};
        vecs[4] = '{op: 2'b00, shamt: 5'd31, din: 32'h0000_0001, dout: 32'h8000_0000};
        vecs[5] = '{op: 2'b01, shamt: 5'd0,  din: 32'hDEAD_BEEF, dout: 32'hDEAD_BEEF};

        repeat (2) @(negedge clk);
        check("rst data_out", sif.data_out, 32'd0);
        check("rst busy", 32'(sif.busy), 32'd0);
        check("rst done", 32'(sif.done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].din, vecs[i].dout);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            rd = $urandom;
            run_op($sformatf("rnd%0d", i), ro, rs, rd, ref_shift(ro, int'(rs), rd));
        end

        // Starts during SHIFT and during the DONE cycle must both be ignored.
        done_cnt = 0;
        @(negedge clk);
        sif.start = 1'b1; sif.op = 2'b00; sif.shamt = 5'd10; sif.data_in = 32'd1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        sif.start = 1'b1; sif.op = 2'b11; sif.shamt = 5'd3; sif.data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        sif.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (sif.done) begin
                done_cnt++;
                sif.start = 1'b1;
            end else begin
                sif.start = 1'b0;
            end
            @(negedge clk);
        end
        sif.start = 1'b0;
        check("ign data_out", sif.data_out, 32'h0000_0400);
        check("ign done_count", 32'(done_cnt), 32'd1);
        check("ign busy", 32'(sif.busy), 32'd0);

        // Asynchronous reset mid-shift aborts with no done pulse.
        @(negedge clk);
        sif.start = 1'b1; sif.op = 2'b00; sif.shamt = 5'd20; sif.data_in = 32'h0000_0001;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst data_out", sif.data_out, 32'd0);
        check("arst busy", 32'(sif.busy), 32'd0);
        check("arst done", 32'(sif.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (sif.done) done_cnt++;
        end
        check("arst no_done", 32'(done_cnt), 32'd0);
        run_op("post_rst", 2'b00, 5'd1, 32'd3, 32'h0000_0006);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
